// File: rtl/colour_seq_pkg.sv
// Shared types for the LED colour sequencer: colour triple, queued command, FSM state.
// Channel order inside rgb_t is red (index 2), green (1), blue (0).
package colour_seq_pkg;

    localparam int CH_RED   = 2;
    localparam int CH_GREEN = 1;
    localparam int CH_BLUE  = 0;

    typedef logic [2:0][7:0] rgb_t;

    typedef struct packed {
        rgb_t        colour;
        logic [15:0] hold;
    } seq_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FADE = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

    // One unit step toward the target; saturates at the target, never wraps.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt) begin
            return cur + 8'd1;
        end else if (cur > tgt) begin
            return cur - 8'd1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/colour_cmd_fifo.sv
// Command queue for the colour sequencer: show-ahead FIFO with flush and occupancy count.
// A push is accepted while full only when a pop happens on the same edge.
module colour_cmd_fifo
    import colour_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     flush,
    input  logic                     push,
    input  seq_cmd_t                 push_data,
    input  logic                     pop,
    output seq_cmd_t                 head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    seq_cmd_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/led_colour_sequencer.sv
// Queued RGB fade/hold sequencer driving a PWM LED driver.
// Optional COLOUR_SEQ_LOOP_EN adds a 'loop' input that re-queues finished commands as a playlist.
module led_colour_sequencer
    import colour_seq_pkg::*;
#(
    parameter int STEP_DIV   = 100000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock_100mhz,
    input  logic                          reset_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [7:0]                    cmd_red,
    input  logic [7:0]                    cmd_green,
    input  logic [7:0]                    cmd_blue,
    input  logic [15:0]                   cmd_hold,
    input  logic                          abort,
`ifdef COLOUR_SEQ_LOOP_EN
    input  logic                          loop,
`endif
    output logic [7:0]                    red,
    output logic [7:0]                    green,
    output logic [7:0]                    blue,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int TW = $clog2(STEP_DIV);

    logic [TW-1:0] tick_cnt_reg;
    logic          tick;
    seq_state_t    state_reg;
    rgb_t          colour_reg;
    rgb_t          target_reg;
    rgb_t          stepped;
    logic [15:0]   hold_val_reg;
    logic [15:0]   hold_cnt_reg;
    seq_cmd_t      head;
    seq_cmd_t      push_data;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;
    logic          hold_done;
    logic          repush;

    assign tick = (tick_cnt_reg == TW'(STEP_DIV - 1));

    always_ff @(posedge clock_100mhz) begin
        if (!reset_n || tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TW'(1);
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        assign stepped[gi] = step_toward(colour_reg[gi], target_reg[gi]);
    end

    assign hold_done = (state_reg == HOLD) && (hold_cnt_reg == 16'd0);

`ifdef COLOUR_SEQ_LOOP_EN
    assign repush = loop && hold_done && !abort;
`else
    assign repush = 1'b0;
`endif

    // Abort blocks both pops and pushes; the loop re-push takes the write slot from the host.
    assign fifo_pop  = !abort && !fifo_empty && ((state_reg == IDLE) || hold_done);
    assign cmd_ready = reset_n && !abort && !repush && !fifo_full;
    assign fifo_push = repush || (cmd_valid && cmd_ready);

    always_comb begin
        push_data.colour = {cmd_red, cmd_green, cmd_blue};
        push_data.hold   = cmd_hold;
        if (repush) begin
            push_data.colour = target_reg;
            push_data.hold   = hold_val_reg;
        end
    end

    colour_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock_100mhz),
        .srst      (!reset_n),
        .flush     (abort),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock_100mhz) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            colour_reg   <= '0;
            target_reg   <= '0;
            hold_val_reg <= '0;
            hold_cnt_reg <= '0;
        end else if (abort) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        target_reg   <= head.colour;
                        hold_val_reg <= head.hold;
                        state_reg    <= FADE;
                    end
                end
                FADE: begin
                    if (colour_reg == target_reg) begin
                        hold_cnt_reg <= hold_val_reg;
                        state_reg    <= HOLD;
                    end else if (tick) begin
                        colour_reg <= stepped;
                    end
                end
                HOLD: begin
                    if (hold_cnt_reg == 16'd0) begin
                        if (!fifo_empty) begin
                            target_reg   <= head.colour;
                            hold_val_reg <= head.hold;
                            state_reg    <= FADE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (tick) begin
                        hold_cnt_reg <= hold_cnt_reg - 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign red   = colour_reg[CH_RED];
    assign green = colour_reg[CH_GREEN];
    assign blue  = colour_reg[CH_BLUE];
    assign busy  = (state_reg != IDLE);

endmodule
